// File: rtl/minmax_tracker_pkg.sv
// Types shared by the min/max tracker and its comparator.
package minmax_tracker_pkg;
`include "cmp_defs.vh"

  typedef enum logic [1:0] {
    IDLE  = `ST_IDLE,
    ACCUM = `ST_ACCUM,
    HOLD  = `ST_HOLD
  } state_t;
endpackage

// File: rtl/cmp_defs.vh
// Shared FSM state encodings for the min/max tracker.
`ifndef CMP_DEFS_VH
`define CMP_DEFS_VH
`define ST_IDLE  2'd0
`define ST_ACCUM 2'd1
`define ST_HOLD  2'd2
`endif

// File: rtl/minmax_tracker_cmp_core.sv
// Combinational three-way compare of a against b, unsigned or two's complement.
module cmp_core #(
  parameter int W      = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         g,
  output logic         e,
  output logic         l
);
  always_comb begin
    if (SIGNED) g = $signed(a) > $signed(b);
    else        g = a > b;
    e = (a == b);
    l = !g && !e;
  end
endmodule

// File: rtl/minmax_tracker.sv
// Per-frame min/max/count tracker with a held result and a sample-to-sample trend flag.
module minmax_tracker
  import minmax_tracker_pkg::*;
#(
  parameter int W      = 8,
  parameter bit SIGNED = 1'b0,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [W-1:0]     s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [W-1:0]     m_min,
  output logic [W-1:0]     m_max,
  output logic [CNT_W-1:0] m_count,
  output logic             g,
  output logic             e,
  output logic             l,
  output logic             trend_valid
);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_next;
  logic [W-1:0]     min_p0, max_p0, prev_p0;
  logic [CNT_W-1:0] cnt_p0;
  logic [W-1:0]     min_nxt, max_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             accept, first;
  logic             g_min, e_min, l_min;
  logic             g_max, e_max, l_max;
  logic             g_prv, e_prv, l_prv;
  logic             unused_cmp;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_ONE;
  endfunction

  cmp_core #(.W(W), .SIGNED(SIGNED)) u_cmp_min (.a(s_data), .b(min_p0),  .g(g_min), .e(e_min), .l(l_min));
  cmp_core #(.W(W), .SIGNED(SIGNED)) u_cmp_max (.a(s_data), .b(max_p0),  .g(g_max), .e(e_max), .l(l_max));
  cmp_core #(.W(W), .SIGNED(SIGNED)) u_cmp_prv (.a(s_data), .b(prev_p0), .g(g_prv), .e(e_prv), .l(l_prv));

  assign unused_cmp = ^{g_min, e_min, e_max, l_max};

  assign s_ready = !rst && !clr && (state != HOLD);
  assign accept  = s_valid && s_ready;
  assign first   = (state == IDLE);

  // The first sample of a frame seeds min/max regardless of the stale registers.
  always_comb begin
    min_nxt = (first || l_min) ? s_data : min_p0;
    max_nxt = (first || g_max) ? s_data : max_p0;
    cnt_nxt = first ? CNT_ONE : sat_inc(cnt_p0);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clr) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE, ACCUM: if (accept) state_next = s_last ? HOLD : ACCUM;
        HOLD:        if (m_ready) state_next = IDLE;
        default:     state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    m_valid = (state == HOLD);
  end

  // Stage p0: accumulators, held result and trend flags
  always_ff @(posedge clk) begin
    if (rst) begin
      min_p0      <= '0;
      max_p0      <= '0;
      prev_p0     <= '0;
      cnt_p0      <= '0;
      m_min       <= '0;
      m_max       <= '0;
      m_count     <= '0;
      trend_valid <= 1'b0;
      g           <= 1'b0;
      e           <= 1'b0;
      l           <= 1'b0;
    end else begin
      trend_valid <= 1'b0;
      g           <= 1'b0;
      e           <= 1'b0;
      l           <= 1'b0;
      if (clr) begin
        cnt_p0  <= '0;
        m_count <= '0;
      end else if (accept) begin
        min_p0  <= min_nxt;
        max_p0  <= max_nxt;
        cnt_p0  <= cnt_nxt;
        prev_p0 <= s_data;
        if (!first) begin
          trend_valid <= 1'b1;
          g           <= g_prv;
          e           <= e_prv;
          l           <= l_prv;
        end
        if (s_last) begin
          m_min   <= min_nxt;
          m_max   <= max_nxt;
          m_count <= cnt_nxt;
        end
      end
    end
  end
endmodule
